// File: rtl/median_filter_unit.sv
// 3x3 median filter behind a single BRAM-style host port: the host loads pixels, sets the
// size, starts the engine, polls done and reads the filtered image back.
module median_filter_unit #(
   parameter int FULLBITWIDTH    = 32,
   parameter int ADDR_WIDTH      = 18,
   parameter int MODE_ADDR_WIDTH = 2,
   parameter int PIX_W           = 8
) (
   input  logic                                  CLK,
   input  logic                                  RST,
   input  logic [FULLBITWIDTH-1:0]               dina_i,
   input  logic [MODE_ADDR_WIDTH+ADDR_WIDTH-1:0] addra_i,
   input  logic                                  wea_i,
   input  logic                                  ena_i,
   output logic [FULLBITWIDTH-1:0]               douta_o
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_SORT  = 3'd2,
      S_WRITE = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t state, state_nx;

   logic [MODE_ADDR_WIDTH-1:0] mode;
   logic [ADDR_WIDTH-1:0]      haddr;
   logic                       host_wr, host_rd, busy, start;

   logic [ADDR_WIDTH-1:0] width, height;
   logic                  done;
   logic [ADDR_WIDTH-1:0] row, col, pix;
   logic [3:0]            fidx;
   logic [PIX_W-1:0]      win [0:8];
   logic [PIX_W-1:0]      median_c, median_q, out_pix;
   logic [PIX_W-1:0]      in_rd_q;
   logic [ADDR_WIDTH-1:0] row_base, rd_addr;
   logic                  is_border, is_last, size_zero;
   logic [3:0]            lt_cnt [0:8];
   logic [3:0]            le_cnt [0:8];
   logic                  found;
   logic                  unused_dina;

   logic [PIX_W-1:0] in_ram  [0:DEPTH-1];
   logic [PIX_W-1:0] out_ram [0:DEPTH-1];

   assign mode        = addra_i[MODE_ADDR_WIDTH+ADDR_WIDTH-1 -: MODE_ADDR_WIDTH];
   assign haddr       = addra_i[ADDR_WIDTH-1:0];
   assign host_wr     = ena_i & wea_i;
   assign host_rd     = ena_i & ~wea_i;
   assign busy        = (state != S_IDLE);
   assign start       = host_wr && !busy && (mode == MODE_ADDR_WIDTH'(1)) && dina_i[0];
   assign unused_dina = ^dina_i[FULLBITWIDTH-1:ADDR_WIDTH];

   assign size_zero = (width == '0) || (height == '0);
   assign is_border = (row == '0) || (col == '0) ||
                      (row == height - ADDR_WIDTH'(1)) || (col == width - ADDR_WIDTH'(1));
   assign is_last   = (row == height - ADDR_WIDTH'(1)) && (col == width - ADDR_WIDTH'(1));
   assign out_pix   = is_border ? win[4] : median_q;

   // Neighbour k of the current pixel: rows k/3 = -1,0,+1 and columns k%3 = -1,0,+1.
   // Out-of-image addresses on border pixels wrap harmlessly; only win[4] is used there.
   always_comb begin
      row_base = pix;
      rd_addr  = pix;
      case (fidx)
         4'd0, 4'd1, 4'd2: row_base = pix - width;
         4'd6, 4'd7, 4'd8: row_base = pix + width;
         default:          row_base = pix;
      endcase
      case (fidx)
         4'd0, 4'd3, 4'd6: rd_addr = row_base - ADDR_WIDTH'(1);
         4'd2, 4'd5, 4'd8: rd_addr = row_base + ADDR_WIDTH'(1);
         default:          rd_addr = row_base;
      endcase
   end

   // Rank selection: the median is any element with at most 4 strictly smaller values
   // and at least 5 values less than or equal to it (handles duplicates).
   always_comb begin
      for (int i = 0; i < 9; i++) begin
         lt_cnt[i] = 4'd0;
         le_cnt[i] = 4'd0;
         for (int j = 0; j < 9; j++) begin
            if (win[j] < win[i])  lt_cnt[i] = lt_cnt[i] + 4'd1;
            if (win[j] <= win[i]) le_cnt[i] = le_cnt[i] + 4'd1;
         end
      end
   end

   always_comb begin
      median_c = win[4];
      found    = 1'b0;
      for (int i = 0; i < 9; i++) begin
         if (!found && (lt_cnt[i] <= 4'd4) && (le_cnt[i] >= 4'd5)) begin
            median_c = win[i];
            found    = 1'b1;
         end
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) state <= S_IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (start) state_nx = size_zero ? S_DONE : S_FETCH;
         S_FETCH: if (fidx == 4'd9) state_nx = S_SORT;
         S_SORT:  state_nx = S_WRITE;
         S_WRITE: state_nx = is_last ? S_DONE : S_FETCH;
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         width    <= '0;
         height   <= '0;
         done     <= 1'b0;
         row      <= '0;
         col      <= '0;
         pix      <= '0;
         fidx     <= 4'd0;
         median_q <= '0;
         for (int k = 0; k < 9; k++) win[k] <= '0;
      end else begin
         if (host_wr && !busy && (mode == MODE_ADDR_WIDTH'(2))) width  <= dina_i[ADDR_WIDTH-1:0];
         if (host_wr && !busy && (mode == MODE_ADDR_WIDTH'(3))) height <= dina_i[ADDR_WIDTH-1:0];
         case (state)
            S_IDLE: begin
               if (start) begin
                  done <= 1'b0;
                  row  <= '0;
                  col  <= '0;
                  pix  <= '0;
                  fidx <= 4'd0;
               end
            end
            S_FETCH: begin
               // RAM data lags the issued address by one cycle.
               fidx <= fidx + 4'd1;
               if (fidx != 4'd0) win[fidx - 4'd1] <= in_rd_q;
            end
            S_SORT: median_q <= median_c;
            S_WRITE: begin
               fidx <= 4'd0;
               pix  <= pix + ADDR_WIDTH'(1);
               if (col == width - ADDR_WIDTH'(1)) begin
                  col <= '0;
                  row <= row + ADDR_WIDTH'(1);
               end else begin
                  col <= col + ADDR_WIDTH'(1);
               end
            end
            S_DONE:  done <= 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (host_wr && !busy && (mode == MODE_ADDR_WIDTH'(0))) in_ram[haddr] <= dina_i[PIX_W-1:0];
      in_rd_q <= in_ram[rd_addr];
      if (state == S_WRITE) out_ram[pix] <= out_pix;
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         douta_o <= '0;
      end else if (host_rd) begin
         douta_o <= '0;
         case (mode)
            MODE_ADDR_WIDTH'(0): douta_o[PIX_W-1:0]      <= out_ram[haddr];
            MODE_ADDR_WIDTH'(1): douta_o[0]              <= done;
            MODE_ADDR_WIDTH'(2): douta_o[ADDR_WIDTH-1:0] <= width;
            default:             douta_o[ADDR_WIDTH-1:0] <= height;
         endcase
      end
   end

endmodule

// File: tb/tb_median_filter_unit.sv
// Directed bench for median_filter_unit: register access, small images with a sorting
// reference model, salt/pepper, tiny and empty images, and reset during a run.
module tb_median_filter_unit;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic [31:0] dina_i = '0;
   logic [19:0] addra_i = '0;
   logic        wea_i = 1'b0;
   logic        ena_i = 1'b0;
   logic [31:0] douta_o;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [7:0]  img [0:63];
   logic [31:0] rd;

   median_filter_unit dut (
      .CLK     (CLK),
      .RST     (RST),
      .dina_i  (dina_i),
      .addra_i (addra_i),
      .wea_i   (wea_i),
      .ena_i   (ena_i),
      .douta_o (douta_o)
   );

   always #5 CLK = ~CLK;

   function automatic logic [19:0] mk(input logic [1:0] m, input int a);
      logic [31:0] av;
      av = a;
      return {m, av[17:0]};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic host_write(input logic [19:0] a, input logic [31:0] d);
      @(negedge CLK);
      addra_i = a;
      dina_i  = d;
      wea_i   = 1'b1;
      ena_i   = 1'b1;
      @(negedge CLK);
      ena_i   = 1'b0;
      wea_i   = 1'b0;
   endtask

   task automatic host_read(input logic [19:0] a, output logic [31:0] d);
      @(negedge CLK);
      addra_i = a;
      wea_i   = 1'b0;
      ena_i   = 1'b1;
      @(negedge CLK);
      ena_i   = 1'b0;
      d       = douta_o;
   endtask

   task automatic set_size(input int w, input int h);
      host_write(mk(2'd2, 0), 32'(w));
      host_write(mk(2'd3, 0), 32'(h));
   endtask

   task automatic load_image(input int n);
      for (int i = 0; i < n; i++) host_write(mk(2'd0, i), {24'd0, img[i]});
   endtask

   task automatic wait_done(input int budget, input string tag);
      logic [31:0] st;
      st = '0;
      for (int i = 0; i < budget; i++) begin
         host_read(mk(2'd1, 0), st);
         if (st == 32'd1) break;
      end
      check(tag, st, 32'd1);
   endtask

   // Reference median: insertion sort of the 3x3 window, middle element.
   function automatic logic [7:0] model_med(input int w, input int r, input int c);
      logic [7:0] v [0:8];
      logic [7:0] t;
      int n;
      n = 0;
      for (int dr = -1; dr <= 1; dr++)
         for (int dc = -1; dc <= 1; dc++) begin
            v[n] = img[(r + dr) * w + (c + dc)];
            n++;
         end
      for (int i = 1; i < 9; i++)
         for (int j = i; j > 0; j--)
            if (v[j] < v[j-1]) begin
               t = v[j]; v[j] = v[j-1]; v[j-1] = t;
            end
      return v[4];
   endfunction

   task automatic check_image(input int w, input int h, input string tag);
      logic [7:0]  e;
      logic [31:0] got;
      for (int r = 0; r < h; r++)
         for (int c = 0; c < w; c++) begin
            if (r == 0 || c == 0 || r == h - 1 || c == w - 1) e = img[r * w + c];
            else                                               e = model_med(w, r, c);
            host_read(mk(2'd0, r * w + c), got);
            check($sformatf("%s_r%0d_c%0d", tag, r, c), got, {24'd0, e});
         end
   endtask

   initial begin
      // Reset: held low for 200 cycles
      repeat (200) @(negedge CLK);
      check("reset_dout", douta_o, 32'd0);
      RST = 1'b1;
      repeat (2) @(negedge CLK);
      host_read(mk(2'd1, 0), rd); check("reset_status", rd, 32'd0);
      host_read(mk(2'd2, 0), rd); check("reset_width", rd, 32'd0);
      host_read(mk(2'd3, 0), rd); check("reset_height", rd, 32'd0);

      // Register read/write
      set_size(430, 554);
      host_read(mk(2'd2, 0), rd); check("width_rw", rd, 32'd430);
      host_read(mk(2'd3, 0), rd); check("height_rw", rd, 32'd554);

      // Noisy 6x5 image against the reference model
      for (int i = 0; i < 30; i++) img[i] = 8'((i * 73 + 29) ^ (i * 11));
      load_image(30);
      set_size(6, 5);
      host_write(mk(2'd1, 0), 32'd1);
      host_read(mk(2'd1, 0), rd); check("busy_status", rd, 32'd0);
      host_write(mk(2'd2, 0), 32'd99);
      host_read(mk(2'd2, 0), rd); check("busy_width_ignored", rd, 32'd6);
      wait_done(2000, "noisy_done");
      host_read(mk(2'd1, 0), rd); check("done_sticky", rd, 32'd1);
      check_image(6, 5, "noisy");

      // Salt/pepper: 5x5 of 0x40 with a 0xFF centre; every output is 0x40
      for (int i = 0; i < 25; i++) img[i] = 8'h40;
      img[12] = 8'hFF;
      load_image(25);
      set_size(5, 5);
      host_write(mk(2'd1, 0), 32'd1);
      wait_done(2000, "salt_done");
      host_read(mk(2'd0, 12), rd); check("salt_center", rd, 32'h40);
      host_read(mk(2'd0, 6), rd);  check("salt_interior", rd, 32'h40);
      host_read(mk(2'd0, 0), rd);  check("salt_corner", rd, 32'h40);

      // 2x2 image: all border pixels, plain copy
      img[0] = 8'd1; img[1] = 8'd2; img[2] = 8'd3; img[3] = 8'd4;
      load_image(4);
      set_size(2, 2);
      host_write(mk(2'd1, 0), 32'd1);
      wait_done(500, "small_done");
      host_read(mk(2'd0, 0), rd); check("small_p0", rd, 32'd1);
      host_read(mk(2'd0, 1), rd); check("small_p1", rd, 32'd2);
      host_read(mk(2'd0, 2), rd); check("small_p2", rd, 32'd3);
      host_read(mk(2'd0, 3), rd); check("small_p3", rd, 32'd4);

      // Empty image: done without processing
      set_size(0, 5);
      host_write(mk(2'd1, 0), 32'd1);
      wait_done(10, "empty_done");

      // Reset during a long run
      set_size(200, 200);
      host_write(mk(2'd1, 0), 32'd1);
      repeat (100) @(negedge CLK);
      RST = 1'b0;
      repeat (5) @(negedge CLK);
      check("midrst_dout", douta_o, 32'd0);
      RST = 1'b1;
      @(negedge CLK);
      host_read(mk(2'd1, 0), rd); check("midrst_status", rd, 32'd0);
      host_read(mk(2'd2, 0), rd); check("midrst_width", rd, 32'd0);
      set_size(3, 3);
      host_read(mk(2'd2, 0), rd); check("midrst_idle_width", rd, 32'd3);

      // Restart with a 3x3 image: centre is the median of 1..9 = 5
      img[0] = 8'd9; img[1] = 8'd1; img[2] = 8'd8;
      img[3] = 8'd2; img[4] = 8'd7; img[5] = 8'd3;
      img[6] = 8'd6; img[7] = 8'd4; img[8] = 8'd5;
      load_image(9);
      host_write(mk(2'd1, 0), 32'd1);
      host_read(mk(2'd1, 0), rd); check("restart_done_cleared", rd, 32'd0);
      wait_done(500, "restart_done");
      host_read(mk(2'd0, 4), rd); check("restart_center", rd, 32'd5);
      host_read(mk(2'd0, 0), rd); check("restart_corner", rd, 32'd9);
      host_read(mk(2'd0, 7), rd); check("restart_edge", rd, 32'd4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
